// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, the grant encoding and the default timeout.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    localparam int         DEFAULT_TIMEOUT = 255;
    localparam int         CNT_W           = 8;
    localparam logic [1:0] SIZE_WORD       = 2'b10;

endpackage

// File: rtl/wait_counter.sv
// Counts busy cycles that pass without a memory acknowledge and flags the
// cycle in which the count would reach TIMEOUT.
module wait_counter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign count_next = count + 1'b1;

    // Hit fires in the busy cycle whose increment would land on the limit,
    // so a limit of N gives exactly N busy cycles before giving up.
    assign hit = en && (count_next == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// the memory stage, with a wait-cycle timeout that completes with an error.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  err
);

    state_t                state;
    state_t                state_next;
    grant_t                last_grant;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  pend_i;
    logic                  pend_d;
    logic                  grant_i;
    logic                  grant_d;
    logic                  busy;
    logic                  timeout_hit;
    logic                  finish;

    // A request whose ready is high this cycle is already being answered.
    assign pend_i = if_req & ~if_ready;
    assign pend_d = d_req & ~d_ready;
    assign stall  = pend_i | pend_d;

    assign busy   = (state != IDLE);
    assign finish = busy & (mem_ack | timeout_hit);

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

    wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (grant_i | grant_d),
        .en  (busy & ~mem_ack),
        .hit (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_d && (!pend_i || last_grant == GNT_I)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (pend_i) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= busy & timeout_hit;
            if (grant_d) begin
                last_grant <= GNT_D;
                addr_q     <= d_addr;
                wdata_q    <= d_wdata;
                we_q       <= d_we;
                size_q     <= d_size;
            end else if (grant_i) begin
                last_grant <= GNT_I;
                addr_q     <= if_addr;
                wdata_q    <= '0;
                we_q       <= 1'b0;
                size_q     <= SIZE_WORD;
            end
            // A timed-out access completes with zero data instead of bus junk.
            if (finish && state == BUSY_I) begin
                if_ready <= 1'b1;
                if_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (finish && state == BUSY_D) begin
                d_ready <= 1'b1;
                d_rdata <= mem_ack ? mem_rdata : '0;
            end
        end
    end

endmodule
